mipi_csi_rx_lane_aligner: RTL and testbench
===========================================

# mipi_csi_rx_lane_aligner

Deskews the per-lane outputs of the CSI-2 RX byte aligners so that the first word of every lane appears in the same cycle.
- Sits between the per-lane byte aligners and the packet decoder.
- Each lane's byte aligner asserts its valid independently, after its lane leaves LP state and finds its sync byte; assertion times can differ by a few byte clocks.
- This block delays the early lanes by a per-packet measured amount and presents one combined, lane-aligned word with a single valid.

## Interface
- MIPI_GEAR, 16, bits per lane per clock (8 or 16)
- MIPI_LANES, 2, number of data lanes (1..4)
- MAX_SKEW, 3, largest lane-to-lane arrival difference tolerated, in clocks (1..7)
- clk_i  in  1  byte clock; all flops are rising-edge
- reset_i  in  1  reset, asynchronous, active-high
- byte_i  in  MIPI_GEAR*MIPI_LANES  per-lane aligned words; lane l occupies [l*MIPI_GEAR +: MIPI_GEAR]
- valid_i  in  MIPI_LANES  per-lane valid from the byte aligners
- lane_byte_o  out  MIPI_GEAR*MIPI_LANES  deskewed words, same lane packing as byte_i
- lane_valid_o  out  1  deskewed data valid
- skew_err_o  out  1  one-cycle pulse: lanes failed to align within MAX_SKEW

## Operation
- **Per-lane history:** each lane has a history of MAX_SKEW+1 stages, hist[l][0..MAX_SKEW]. Both data and valid are shifted every clock, unconditionally.
  - hist[l][0] takes the current inputs.
  - Tap k is the input sampled k clocks earlier.
- **FSM states:** IDLE, WAIT_LANES, ALIGNED, DRAIN.
- **IDLE:**
  - On the first edge with any valid_i bit high: skew_cnt <= 1, and arrival[l] <= 0 for every high lane.
  - Mark those lanes seen. The seen bits are cleared on entry to IDLE.
  - If all lanes are high on that edge: go to ALIGNED with all taps = 0. Otherwise go to WAIT_LANES.
- **WAIT_LANES:**
  - Each edge, every newly high, unseen lane gets arrival[l] <= skew_cnt. Then skew_cnt increments.
  - When the last lane is seen: tap[l] <= skew_cnt − arrival[l] for all lanes, then go to ALIGNED.
  - If skew_cnt == MAX_SKEW on an edge where lanes are still unseen: pulse skew_err_o and go to DRAIN.
- **ALIGNED:**
  - lane_byte_o[l] <= hist[l][tap[l]].
  - lane_valid_o <= AND over lanes of hist_valid[l][tap[l]].
  - When that AND evaluates low: lane_valid_o <= 0 and go to DRAIN.
- **DRAIN:** outputs hold invalid (lane_valid_o = 0). Return to IDLE on the first edge with valid_i == 0.
- **Taps and counter:** taps are frozen while in ALIGNED. tap and skew_cnt width is clog2(MAX_SKEW+1); skew_cnt saturates and never wraps.
- **Boundary cases:**
  - A lane whose valid drops during WAIT_LANES stays seen. The AND in ALIGNED will then end the packet.
  - Lanes arriving on the same edge get equal arrival values.
  - MIPI_LANES == 1: every packet goes straight to ALIGNED with tap 0.
  - When lane_valid_o is low, lane_byte_o holds its last value and is don't-care.

## Timing
- **Reset values:** lane_byte_o = 0, lane_valid_o = 0, skew_err_o = 0, state = IDLE; all history, taps, counters and seen bits cleared. Reset mid-packet aborts immediately and asynchronously, with no error pulse.
- **Latency:**
  - The last-arriving lane sees 2 edges: the sampling edge captures into hist and decides the taps, and the next edge registers the output.
  - A lane arriving k clocks earlier sees 2+k edges.
- **Valid behaviour:** the first word with lane_valid_o high carries every lane's first valid word, i.e. its sync word. lane_valid_o stays high while all delayed valids are high; there is no backpressure.
- **Error timing:** skew_err_o is high for exactly one cycle, on the edge after the MAX_SKEW-th clock of waiting.
- **Recovery:** a new packet is accepted only after valid_i has returned to all-zero.

## Structure
- **Shared package:** mipi_csi_rx_pkg holds the FSM state encoding, MAX_SKEW default, and the lane-packing helper width constants, shared with the byte aligner and packet decoder.
- **Sub-module:** mipi_csi_rx_lane_delay, one instance per lane. It contains the history shift register plus a tap mux: inputs data, valid and tap; outputs the delayed data and valid.
- **Top level:** contains the FSM, the arrival/seen registers, skew_cnt and the output registers.

## Test plan
- **Zero skew:** 2 lanes, valid_i = 2'b11 on the same edge, first words 0xB8B8/0xB8B8 then incrementing → lane_valid_o high 2 edges later, with lane words 0xB8B8 on both lanes in the same cycle.
- **Skew of 2:** lane0 valid 2 clocks before lane1, each lane's first word = 0x00B8 → taps {2,0}; first valid output shows 0x00B8 on both lanes; the lane0 stream is delayed 2 extra clocks thereafter.
- **Skew exceeds limit:** lane1 valid 4 clocks after lane0, MAX_SKEW = 3 → skew_err_o one-cycle pulse, lane_valid_o never rises; after valid_i = 0 the next aligned packet is accepted normally.
- **End of packet:** in ALIGNED, drop lane1 valid → lane_valid_o falls once the delayed lane1 valid falls. Raising valid_i again before all lanes go low produces no output (stays in DRAIN).
- **Reset mid-packet:** assert reset_i asynchronously while in ALIGNED with 4 lanes, taps {0,1,3,2} → all outputs 0 immediately; the post-reset packet with zero skew uses taps {0,0,0,0}.

Source files
------------

// File: rtl/mipi_csi_rx_pkg.sv
// mipi_csi_rx_pkg: shared CSI-2 RX types, defaults and lane-packing helpers.
package mipi_csi_rx_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_LANES, ALIGNED, DRAIN} rx_state_e;

    localparam int MIPI_GEAR_DEF  = 16;
    localparam int MIPI_LANES_DEF = 2;
    localparam int MAX_SKEW_DEF   = 3;

    function automatic int lane_bus_w(input int gear, input int lanes);
        return gear * lanes;
    endfunction

    // Width able to hold any delay 0..max_skew.
    function automatic int tap_width(input int max_skew);
        return $clog2(max_skew + 1);
    endfunction

endpackage

// File: rtl/mipi_csi_rx_lane_delay.sv
// mipi_csi_rx_lane_delay: per-lane history shift register with selectable tap.
module mipi_csi_rx_lane_delay import mipi_csi_rx_pkg::*; #(
    parameter int GEAR  = MIPI_GEAR_DEF,
    parameter int DEPTH = MAX_SKEW_DEF + 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [GEAR-1:0]               data_i,
    input  logic                          valid_i,
    input  logic [tap_width(DEPTH-1)-1:0] tap_i,
    output logic [GEAR-1:0]               data_o,
    output logic                          valid_o
);

    logic [GEAR-1:0]  hist_data [DEPTH];
    logic [DEPTH-1:0] hist_valid;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < DEPTH; k++) hist_data[k] <= '0;
            hist_valid <= '0;
        end else begin
            hist_data[0] <= data_i;
            for (int k = 1; k < DEPTH; k++) hist_data[k] <= hist_data[k-1];
            hist_valid <= {hist_valid[DEPTH-2:0], valid_i};
        end
    end

    assign data_o  = hist_data[tap_i];
    assign valid_o = hist_valid[tap_i];

endmodule

// File: rtl/mipi_csi_rx_lane_aligner.sv
// mipi_csi_rx_lane_aligner: measures per-packet lane arrival skew and delays
// early lanes so every lane's first word leaves in the same cycle.
module mipi_csi_rx_lane_aligner import mipi_csi_rx_pkg::*; #(
    parameter int MIPI_GEAR  = MIPI_GEAR_DEF,
    parameter int MIPI_LANES = MIPI_LANES_DEF,
    parameter int MAX_SKEW   = MAX_SKEW_DEF
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [lane_bus_w(MIPI_GEAR,MIPI_LANES)-1:0] byte_i,
    input  logic [MIPI_LANES-1:0]                     valid_i,
    output logic [lane_bus_w(MIPI_GEAR,MIPI_LANES)-1:0] lane_byte_o,
    output logic                                      lane_valid_o,
    output logic                                      skew_err_o
);

    localparam int TW = tap_width(MAX_SKEW);
    localparam logic [TW-1:0] SKEW_LIM = TW'(MAX_SKEW);

    rx_state_e             state;
    logic [TW-1:0]         skew_cnt;
    logic [TW-1:0]         arrival [MIPI_LANES];
    logic [TW-1:0]         arr_nx  [MIPI_LANES];
    logic [TW-1:0]         tap     [MIPI_LANES];
    logic [MIPI_LANES-1:0] seen, seen_nx;
    logic [MIPI_GEAR-1:0]  dly_data [MIPI_LANES];
    logic [MIPI_LANES-1:0] dly_valid;
    logic                  all_v;

    for (genvar g = 0; g < MIPI_LANES; g++) begin : g_lane
        mipi_csi_rx_lane_delay #(.GEAR(MIPI_GEAR), .DEPTH(MAX_SKEW + 1)) u_dly (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .data_i  (byte_i[g*MIPI_GEAR +: MIPI_GEAR]),
            .valid_i (valid_i[g]),
            .tap_i   (tap[g]),
            .data_o  (dly_data[g]),
            .valid_o (dly_valid[g])
        );
    end

    // Lanes first seen this edge are stamped with the current count.
    always_comb begin
        seen_nx = seen | valid_i;
        for (int l = 0; l < MIPI_LANES; l++)
            arr_nx[l] = (valid_i[l] && !seen[l]) ? skew_cnt : arrival[l];
    end

    assign all_v = &dly_valid;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            skew_cnt     <= '0;
            seen         <= '0;
            lane_byte_o  <= '0;
            lane_valid_o <= 1'b0;
            skew_err_o   <= 1'b0;
            for (int l = 0; l < MIPI_LANES; l++) begin
                arrival[l] <= '0;
                tap[l]     <= '0;
            end
        end else begin
            skew_err_o <= 1'b0;
            case (state)
                IDLE: if (|valid_i) begin
                    skew_cnt <= TW'(1);
                    seen     <= valid_i;
                    for (int l = 0; l < MIPI_LANES; l++) begin
                        arrival[l] <= '0;
                        tap[l]     <= '0;
                    end
                    state <= &valid_i ? ALIGNED : WAIT_LANES;
                end
                WAIT_LANES: begin
                    arrival <= arr_nx;
                    seen    <= seen_nx;
                    if (&seen_nx) begin
                        for (int l = 0; l < MIPI_LANES; l++) tap[l] <= skew_cnt - arr_nx[l];
                        state <= ALIGNED;
                    end else if (skew_cnt == SKEW_LIM) begin
                        skew_err_o <= 1'b1;
                        state      <= DRAIN;
                    end
                    if (skew_cnt != SKEW_LIM) skew_cnt <= skew_cnt + TW'(1);
                end
                ALIGNED: begin
                    lane_valid_o <= all_v;
                    if (all_v)
                        for (int l = 0; l < MIPI_LANES; l++)
                            lane_byte_o[l*MIPI_GEAR +: MIPI_GEAR] <= dly_data[l];
                    else
                        state <= DRAIN;
                end
                DRAIN: if (valid_i == '0) begin
                    seen  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi_rx_lane_aligner.sv
// tb_mipi_csi_rx_lane_aligner: scoreboard bench for the 4-lane, 16-bit lane aligner.
module tb_mipi_csi_rx_lane_aligner;

    typedef struct packed {
        int          cyc;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [63:0] byte_i;
    logic [3:0]  valid_i;
    logic [63:0] lane_byte_o;
    logic        lane_valid_o;
    logic        skew_err_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   err_q[$];
    exp_t e;
    int   ec;

    mipi_csi_rx_lane_aligner #(.MIPI_GEAR(16), .MIPI_LANES(4), .MAX_SKEW(3)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .byte_i       (byte_i),
        .valid_i      (valid_i),
        .lane_byte_o  (lane_byte_o),
        .lane_valid_o (lane_valid_o),
        .skew_err_o   (skew_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents a word or an error pulse.
    always @(negedge clk) begin
        if (lane_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid cyc=%0d got=%h", cyc, lane_byte_o);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.data != lane_byte_o) begin
                    errors++;
                    $display("FAIL out_word cyc=%0d got=%h required cyc=%0d data=%h", cyc, lane_byte_o, e.cyc, e.data);
                end
            end
        end
        if (skew_err_o) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_skew_err cyc=%0d", cyc);
            end else begin
                ec = err_q.pop_front();
                if (ec != cyc) begin
                    errors++;
                    $display("FAIL skew_err_cycle got=%0d required=%0d", cyc, ec);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Lane l is valid for ln[l] cycles from cycle st[l], carrying first[l]+i.
    // lat: hand-derived cycles from c=0 to the first output (-1: none); elat likewise for skew_err_o.
    task automatic drive_pkt(input logic [3:0][7:0] st, input logic [3:0][7:0] ln,
                             input logic [3:0][15:0] first, input int ncyc,
                             input int lat, input int nexp, input int elat);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int j = 0; j < nexp; j++) begin
                    exp_t x;
                    x.cyc = cyc + lat + j;
                    for (int l = 0; l < 4; l++) x.data[l*16 +: 16] = first[l] + 16'(j);
                    exp_q.push_back(x);
                end
                if (elat >= 0) err_q.push_back(cyc + elat);
            end
            for (int l = 0; l < 4; l++) begin
                logic v;
                v = (c >= int'(st[l])) && (c < int'(st[l]) + int'(ln[l]));
                valid_i[l] = v;
                byte_i[l*16 +: 16] = v ? first[l] + 16'(c - int'(st[l])) : (16'hDE00 | 16'(c));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_i = '0;
            byte_i  = '0;
        end
    endtask

    initial begin
        reset_i = 1'b1;
        valid_i = '0;
        byte_i  = '0;
        repeat (2) @(negedge clk);
        chk("reset_byte", lane_byte_o, 64'd0);
        chk("reset_valid", 64'(lane_valid_o), 64'd0);
        chk("reset_err", 64'(skew_err_o), 64'd0);
        reset_i = 1'b0;
        idle(2);

        // Zero skew: all lanes on the same edge.
        drive_pkt({8'd0, 8'd0, 8'd0, 8'd0}, {8'd6, 8'd6, 8'd6, 8'd6},
                  {16'hB8B8, 16'hB8B8, 16'hB8B8, 16'hB8B8}, 8, 2, 6, -1);
        idle(3);

        // Lane0 two clocks early: taps {2,0,0,0}.
        drive_pkt({8'd2, 8'd2, 8'd2, 8'd0}, {8'd6, 8'd6, 8'd6, 8'd6},
                  {16'h00B8, 16'h00B8, 16'h00B8, 16'h00B8}, 10, 4, 6, -1);
        idle(3);

        // Skew of exactly MAX_SKEW is still accepted.
        drive_pkt({8'd0, 8'd0, 8'd3, 8'd0}, {8'd5, 8'd5, 8'd5, 8'd5},
                  {16'h4000, 16'h3000, 16'h2000, 16'h1000}, 10, 5, 5, -1);
        idle(3);

        // Lane1 four clocks late: error pulse, no output.
        drive_pkt({8'd0, 8'd0, 8'd4, 8'd0}, {8'd6, 8'd6, 8'd6, 8'd6},
                  {16'h0AA0, 16'h0BB0, 16'h0CC0, 16'h0DD0}, 10, -1, 0, 4);
        idle(3);
        drive_pkt({8'd0, 8'd0, 8'd0, 8'd0}, {8'd4, 8'd4, 8'd4, 8'd4},
                  {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 6, 2, 4, -1);
        idle(3);

        // End of packet: lane1 drops early, then everything re-raises while draining.
        drive_pkt({8'd0, 8'd0, 8'd0, 8'd0}, {8'd8, 8'd8, 8'd3, 8'd8},
                  {16'h7000, 16'h6000, 16'h5000, 16'h4000}, 6, 2, 3, -1);
        drive_pkt({8'd0, 8'd0, 8'd0, 8'd0}, {8'd4, 8'd4, 8'd4, 8'd4},
                  {16'h9900, 16'h9900, 16'h9900, 16'h9900}, 4, -1, 0, -1);
        idle(3);
        drive_pkt({8'd0, 8'd0, 8'd0, 8'd0}, {8'd3, 8'd3, 8'd3, 8'd3},
                  {16'hA004, 16'hA003, 16'hA002, 16'hA001}, 5, 2, 3, -1);
        idle(3);

        // Reset mid-packet with taps {0,1,3,2}.
        drive_pkt({8'd1, 8'd0, 8'd2, 8'd3}, {8'd12, 8'd12, 8'd12, 8'd12},
                  {16'h4400, 16'h3300, 16'h2200, 16'h1100}, 9, 5, 4, -1);
        @(posedge clk);
        #1 chk("valid_before_reset", 64'(lane_valid_o), 64'd1);
        #1 reset_i = 1'b1;
        #1;
        chk("async_reset_byte", lane_byte_o, 64'd0);
        chk("async_reset_valid", 64'(lane_valid_o), 64'd0);
        chk("async_reset_err", 64'(skew_err_o), 64'd0);
        idle(2);
        reset_i = 1'b0;
        idle(2);
        drive_pkt({8'd0, 8'd0, 8'd0, 8'd0}, {8'd4, 8'd4, 8'd4, 8'd4},
                  {16'hC3C3, 16'hC2C2, 16'hC1C1, 16'hC0C0}, 6, 2, 4, -1);
        idle(4);

        chk("words_outstanding", 64'(exp_q.size()), 64'd0);
        chk("errs_outstanding", 64'(err_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
